linear_network_multicast_seq: RTL

Pipelined, back-pressured linear (daisy-chain) distribution network. It delivers each input word to any subset of `NUM_NODE` nodes chosen by a one-hot-per-node destination mask. There is one register stage per node, with a valid/ready handshake on the input and on every node output. It sits between a single producer (e.g. buffer read port) and a row of PEs, where the unicast chain cannot serve multicast or stall on a busy PE.

---
 rtl/linear_network_multicast_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/linear_network_multicast_seq.sv
// Daisy-chain multicast distribution network: one register stage per node, each word is delivered
// to every node named in its destination mask, with per-node valid/ready back-pressure.
module linear_network_multicast_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_cmd,
  output logic                           o_ready,
  output logic [NUM_NODE-1:0]            o_valid,
  output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus,
  input  logic [NUM_NODE-1:0]            i_ready,
  output logic                           o_busy
);

  logic [NUM_NODE-1:0]                 vld_q, vld_d;
  logic [NUM_NODE-1:0][DATA_WIDTH-1:0] dat_q, dat_d;
  logic [NUM_NODE-1:0][NUM_NODE-1:0]   msk_q, msk_d;

  logic [NUM_NODE-1:0] local_done;
  logic [NUM_NODE-1:0] fwd_need;
  logic [NUM_NODE-1:0] vacate;
  logic [NUM_NODE:0]   acc;
  logic                in_fire;

  // Mask with every bit at position >= k set; used to drop nodes already passed.
  function automatic logic [NUM_NODE-1:0] keep_from(input int k);
    logic [NUM_NODE-1:0] m;
    for (int j = 0; j < int'(NUM_NODE); j++) begin
      m[j] = (j >= k);
    end
    return m;
  endfunction

  // Ready chain runs from the last stage back towards the input in a single pass.
  always_comb begin : ready_chain
    local_done     = '0;
    fwd_need       = '0;
    vacate         = '0;
    acc            = '0;
    acc[NUM_NODE]  = 1'b1;
    for (int k = int'(NUM_NODE) - 1; k >= 0; k--) begin
      local_done[k] = !msk_q[k][k] || i_ready[k];
      for (int j = k + 1; j < int'(NUM_NODE); j++) begin
        fwd_need[k] = fwd_need[k] | msk_q[k][j];
      end
      vacate[k] = i_en && vld_q[k] && local_done[k] && (!fwd_need[k] || acc[k+1]);
      acc[k]    = !vld_q[k] || vacate[k];
    end
  end

  always_comb begin : outputs
    o_ready = i_en && acc[0];
    for (int k = 0; k < int'(NUM_NODE); k++) begin
      o_valid[k] = i_en && vld_q[k] && msk_q[k][k];
    end
    o_data_bus = dat_q;
    o_busy     = |vld_q;
  end

  always_comb begin : next_state
    vld_d   = vld_q;
    dat_d   = dat_q;
    msk_d   = msk_q;
    in_fire = i_valid && o_ready;

    for (int k = 0; k < int'(NUM_NODE); k++) begin
      if (vacate[k]) begin
        vld_d[k] = 1'b0;
      end
    end

    // A zero mask is accepted but never occupies a stage.
    if (in_fire && (|i_cmd)) begin
      vld_d[0] = 1'b1;
      dat_d[0] = i_data_bus;
      msk_d[0] = i_cmd;
    end

    // Loads are applied after the vacate clears so a refilled stage stays valid.
    for (int k = 1; k < int'(NUM_NODE); k++) begin
      if (vacate[k-1] && fwd_need[k-1]) begin
        vld_d[k] = 1'b1;
        dat_d[k] = dat_q[k-1];
        msk_d[k] = msk_q[k-1] & keep_from(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
      msk_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      msk_q <= msk_d;
    end
  end

endmodule
